// File: rtl/mips_cpu_div_ctrl.sv
// mips_cpu_div_ctrl
// Sequencer between decode/execute and mips_cpu_divider. It accepts DIV/DIVU,
// hands the divider operand magnitudes, waits for done, restores the signs of
// quotient and remainder and writes the architectural HI/LO pair. MTHI/MTLO
// writes are handled here too, and busy stalls the pipeline while a divide is
// in flight.
// Optional build macro: DIV_DBZ_FLAG_EN adds a sticky divide-by-zero flag
// output (dbz_flag), set by a zero-divisor divide and cleared by MTLO or reset.
module mips_cpu_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             dvd_start,
    output logic [WIDTH-1:0] dvd_dividend,
    output logic [WIDTH-1:0] dvd_divisor,
    input  logic [WIDTH-1:0] dvd_quotient,
    input  logic [WIDTH-1:0] dvd_remainder,
`ifdef DIV_DBZ_FLAG_EN
    output logic             dbz_flag,
`endif
    input  logic             dvd_done,
    input  logic             dvd_dbz
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FIX    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             negQuot_q, negQuot_d;
    logic             negRem_q, negRem_d;
    logic             dbzLat_q, dbzLat_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
`ifdef DIV_DBZ_FLAG_EN
    logic             dbzFlag_q, dbzFlag_d;
`endif

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is the correct unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Next-state and datapath updates for the divide sequencer and HI/LO.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        negQuot_d  = negQuot_q;
        negRem_d   = negRem_q;
        dbzLat_d   = dbzLat_q;
`ifdef DIV_DBZ_FLAG_EN
        dbzFlag_d  = dbzFlag_q;
`endif
        case (state_q)
            IDLE: begin
                if (mthi_en) begin
                    hi_d = wr_data;
                end
                if (mtlo_en) begin
                    lo_d = wr_data;
`ifdef DIV_DBZ_FLAG_EN
                    dbzFlag_d = 1'b0;
`endif
                end
                if (div_start) begin
                    negQuot_d  = div_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    negRem_d   = div_signed & rs_val[WIDTH-1];
                    dividend_d = div_signed ? magnitude(rs_val) : rs_val;
                    divisor_d  = div_signed ? magnitude(rt_val) : rt_val;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (dvd_done) begin
                    quot_d   = dvd_quotient;
                    rem_d    = dvd_remainder;
                    dbzLat_d = dvd_dbz;
                    state_d  = FIX;
                end
            end
            FIX: begin
                if (!dbzLat_q) begin
                    lo_d = negQuot_q ? -quot_q : quot_q;
                    hi_d = negRem_q ? -rem_q : rem_q;
                end
`ifdef DIV_DBZ_FLAG_EN
                else begin
                    dbzFlag_d = 1'b1;
                end
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        start_d = (state_d == LAUNCH);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            negQuot_q  <= 1'b0;
            negRem_q   <= 1'b0;
            dbzLat_q   <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
            dbzFlag_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            negQuot_q  <= negQuot_d;
            negRem_q   <= negRem_d;
            dbzLat_q   <= dbzLat_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
`ifdef DIV_DBZ_FLAG_EN
            dbzFlag_q  <= dbzFlag_d;
`endif
        end
    end

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign busy         = busy_q;
    assign dvd_start    = start_q;
    assign dvd_dividend = dividend_q;
    assign dvd_divisor  = divisor_q;
`ifdef DIV_DBZ_FLAG_EN
    assign dbz_flag     = dbzFlag_q;
`endif

endmodule

// File: tb/tb_mips_cpu_div_ctrl.sv
// tb_mips_cpu_div_ctrl
// Directed bench for mips_cpu_div_ctrl with a behavioural divider model.
// Expected HI/LO results are queued when a divide is issued and checked by a
// monitor when busy falls. Build with DIV_DBZ_FLAG_EN to also check dbz_flag.
module tb_mips_cpu_div_ctrl;

    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mthi_en = 1'b0;
    logic        mtlo_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        dvd_start;
    logic [31:0] dvd_dividend;
    logic [31:0] dvd_divisor;
    logic [31:0] dvd_quotient = '0;
    logic [31:0] dvd_remainder = '0;
    logic        dvd_done = 1'b0;
    logic        dvd_dbz = 1'b0;
`ifdef DIV_DBZ_FLAG_EN
    logic        dbz_flag;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t expQ[$];
    int   vecCount = 0;
    int   errCount = 0;
    int   startCount = 0;
    logic prevBusy = 1'b0;

    logic [31:0] modA = '0;
    logic [31:0] modB = '0;
    int          modCnt = 0;

    mips_cpu_div_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .mthi_en      (mthi_en),
        .mtlo_en      (mtlo_en),
        .wr_data      (wr_data),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .dvd_start    (dvd_start),
        .dvd_dividend (dvd_dividend),
        .dvd_divisor  (dvd_divisor),
        .dvd_quotient (dvd_quotient),
        .dvd_remainder(dvd_remainder),
`ifdef DIV_DBZ_FLAG_EN
        .dbz_flag     (dbz_flag),
`endif
        .dvd_done     (dvd_done),
        .dvd_dbz      (dvd_dbz)
    );

    always #5 clk = ~clk;

    // Behavioural unsigned divider: level done after DIV_LAT cycles, cleared on start.
    always @(posedge clk) begin
        if (dvd_start) begin
            modA     <= dvd_dividend;
            modB     <= dvd_divisor;
            modCnt   <= DIV_LAT;
            dvd_done <= 1'b0;
        end else if (modCnt > 1) begin
            modCnt <= modCnt - 1;
        end else if (modCnt == 1) begin
            modCnt        <= 0;
            dvd_done      <= 1'b1;
            dvd_dbz       <= (modB == 32'd0);
            dvd_quotient  <= (modB == 32'd0) ? 32'hFFFF_FFFF : modA / modB;
            dvd_remainder <= (modB == 32'd0) ? modA : modA % modB;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: on each busy fall, pop the queued result and compare.
    always @(negedge clk) begin
        exp_t e;
        if (dvd_start) startCount++;
        if (prevBusy && !busy) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_busy_fall", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("hi", hi, e.hi);
                checkOutput("lo", lo, e.lo);
                checkOutput("dvd_start_pulses", startCount, 32'd1);
`ifdef DIV_DBZ_FLAG_EN
                checkOutput("dbz_flag", {31'd0, dbz_flag}, {31'd0, e.dbz});
`endif
            end
            startCount = 0;
        end
        prevBusy = busy;
    end

    task automatic applyStimulus(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic withMthi, input logic [31:0] expHi,
                                 input logic [31:0] expLo, input logic expDbz);
        exp_t e;
        @(negedge clk);
        div_start  = 1'b1;
        div_signed = sgn;
        rs_val     = rs;
        rt_val     = rt;
        mthi_en    = withMthi;
        wr_data    = 32'h0000_0055;
        e.hi = expHi;
        e.lo = expLo;
        e.dbz = expDbz;
        expQ.push_back(e);
        @(negedge clk);
        div_start = 1'b0;
        mthi_en   = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("busy_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_dvd_start", {31'd0, dvd_start}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] DIVU 100/7");
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);
        waitIdle();

        $display("[TB] DIV -7/2 and 7/-2");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        waitIdle();
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD, 1'b0);
        waitIdle();

        $display("[TB] most-negative / -1, signed and unsigned");
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0);
        waitIdle();

        $display("[TB] same-cycle MTHI with DIVU 20/6");
        applyStimulus(1'b0, 32'd20, 32'd6, 1'b1, 32'd2, 32'd3, 1'b0);
        checkOutput("mthi_with_start", hi, 32'h0000_0055);
        waitIdle();

        $display("[TB] MTHI/MTLO then DIVU 5/0");
        mthi_en = 1'b1;
        wr_data = 32'hAAAA_5555;
        @(negedge clk);
        mthi_en = 1'b0;
        mtlo_en = 1'b1;
        wr_data = 32'h0000_1234;
        @(negedge clk);
        mtlo_en = 1'b0;
        checkOutput("mthi_hi", hi, 32'hAAAA_5555);
        checkOutput("mtlo_lo", lo, 32'h0000_1234);
        applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, 32'hAAAA_5555, 32'h0000_1234, 1'b1);
        waitIdle();
        mtlo_en = 1'b1;
        wr_data = 32'd0;
        @(negedge clk);
        mtlo_en = 1'b0;
        checkOutput("mtlo_clear_lo", lo, 32'd0);
`ifdef DIV_DBZ_FLAG_EN
        checkOutput("dbz_flag_cleared", {31'd0, dbz_flag}, 32'd0);
`endif

        $display("[TB] DIVU 9/3 with MTHI and div_start during WAIT");
        applyStimulus(1'b0, 32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        mthi_en   = 1'b1;
        wr_data   = 32'h0000_DEAD;
        div_start = 1'b1;
        rs_val    = 32'd50;
        rt_val    = 32'd5;
        @(negedge clk);
        mthi_en   = 1'b0;
        div_start = 1'b0;
        waitIdle();

        $display("[TB] reset during DIVU 1000/3, then DIVU 8/3");
        applyStimulus(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 32'd8, 32'd3, 1'b0, 32'd2, 32'd2, 1'b0);
        waitIdle();

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
